pattern_word_gen: RTL and testbench
===================================

PATTERN_WORD_GEN -- requirements
Module: pattern_word_gen

Interface
REQ-001 Parameter WIDTH, 8, word width in bits; legal range 4..32.
REQ-002 Parameter FRAME_LEN, 8, words per frame; legal range 1..65535.
REQ-003 Parameter TAPS, 8'hB8 (zero-extended to WIDTH), Galois LFSR feedback mask for PRBS mode.
REQ-004 clk_word  in  1  word clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  frame start request, sampled in IDLE only.
REQ-007 stop  in  1  abort request, sampled in any state.
REQ-008 mode  in  2  00 walking-one, 01 incrementing count, 10 PRBS, 11 fixed pattern.
REQ-009 pattern  in  WIDTH  fixed word for mode 11; PRBS seed for mode 10.
REQ-010 continuous  in  1  1 = start the next frame immediately after the current one ends.
REQ-011 ready  in  1  downstream accepts the current word.
REQ-012 word  out  WIDTH  current word; valid while enable=1.
REQ-013 enable  out  1  word valid; 1 only in SEND.
REQ-014 busy  out  1  1 in any state other than IDLE.
REQ-015 frame_done  out  1  single-cycle pulse on completion of a frame.
REQ-016 word_cnt  out  16  number of words accepted so far in the current frame (0..FRAME_LEN-1).

Function
REQ-017 The FSM SHALL have two states, IDLE and SEND, encoded in registers clocked by clk_word.
REQ-018 In IDLE, start=1 and stop=0 SHALL latch mode, pattern and continuous, load the first word, and enter SEND at the same edge; enable=1 on the next cycle.
REQ-019 First word per mode SHALL be: walking-one 1; count 1; PRBS pattern, or all-ones if pattern=0; fixed pattern.
REQ-020 A transfer SHALL occur at an edge where enable=1 and ready=1; at that edge word advances to the next value and word_cnt increments, giving no bubble between consecutive transfers.
REQ-021 While enable=1 and ready=0, word and word_cnt SHALL hold stable.
REQ-022 Walking-one next value SHALL be a rotate-left by 1, so the MSB wraps to the LSB.
REQ-023 Count next value SHALL be word+1 modulo 2^WIDTH, wrapping from all-ones to 0.
REQ-024 PRBS next value SHALL be (word>>1) XOR (word[0] ? TAPS : 0).
REQ-025 Fixed-pattern next value SHALL be the latched pattern.
REQ-026 On the transfer with word_cnt=FRAME_LEN-1, frame_done SHALL pulse for one cycle and word_cnt SHALL return to 0.
REQ-027 In that case, if latched continuous=1, the FSM SHALL stay in SEND and the generator SHALL continue from its next value without re-initialisation.
REQ-028 In that case, if latched continuous=0, the FSM SHALL enter IDLE and enable SHALL drop to 0 on the next cycle.
REQ-029 stop=1 in SEND SHALL force IDLE at the next edge, with enable=0, word_cnt=0 and no frame_done, even if a transfer or frame end coincides.
REQ-030 start and stop both 1 in IDLE: stop SHALL win and the FSM SHALL remain in IDLE.
REQ-031 start while in SEND SHALL be ignored; changes to mode, pattern or continuous SHALL be ignored until the next start from IDLE.
REQ-032 In IDLE, word SHALL hold its last value and enable SHALL be 0.

Reset
REQ-033 rst=0 SHALL immediately force IDLE, word=0, enable=0, busy=0, frame_done=0, word_cnt=0, latched mode/pattern/continuous=0, independent of clk_word.
REQ-034 Reset asserted mid-frame SHALL discard the frame with no frame_done; after release, the first start SHALL behave as in REQ-018.

Verification
REQ-035 WIDTH=8, FRAME_LEN=8, mode 00, ready=1, start pulse -> words 01,02,04,08,10,20,40,80 on consecutive cycles; frame_done high alongside 80; enable=0 next cycle.
REQ-036 Mode 01, continuous=1, FRAME_LEN=4, WIDTH=4 -> 1,2,...,F,0,1,... across frames; frame_done every 4th transfer; busy stays 1.
REQ-037 Mode 10, pattern=0 -> first word FF, second word FF^B8>>... computed by REQ-024 (FF -> 7F^B8 = C7); ready toggled randomly -> sequence unchanged and held stable during ready=0.
REQ-038 Mode 11, pattern=A5, ready=0 for 5 cycles after start -> word=A5, enable=1, word_cnt=0 held; then ready=1 -> 8 transfers, word_cnt 0..7.
REQ-039 stop asserted coinciding with the frame's last transfer -> IDLE next cycle, no frame_done; simultaneous start+stop in IDLE -> stays IDLE.
REQ-040 rst pulsed low mid-frame between clock edges -> outputs zero immediately; next start restarts at first word with word_cnt=0.

Source files
------------

// File: rtl/pattern_word_gen.sv
// Framed test-word generator: walking-one, counter, Galois PRBS or fixed pattern,
// streamed under a valid/ready handshake in frames of FRAME_LEN words.
module pattern_word_gen #(
    parameter int              WIDTH     = 8,
    parameter int              FRAME_LEN = 8,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(8'hB8)
) (
    input  logic             clk_word,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] pattern,
    input  logic             continuous,
    input  logic             ready,
    output logic [WIDTH-1:0] word,
    output logic             enable,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]      LAST_CNT = 16'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic             cont_q, cont_d;
    logic             last_s;

    // A zero seed would lock the LFSR, so PRBS substitutes all-ones.
    function automatic logic [WIDTH-1:0] first_word(input logic [1:0] m, input logic [WIDTH-1:0] p);
        case (m)
            2'b00:   first_word = ONE;
            2'b01:   first_word = ONE;
            2'b10:   first_word = (p == ZERO) ? ONES : p;
            default: first_word = p;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m, input logic [WIDTH-1:0] w,
                                                   input logic [WIDTH-1:0] p);
        case (m)
            2'b00:   next_word = {w[WIDTH-2:0], w[WIDTH-1]};
            2'b01:   next_word = w + ONE;
            2'b10:   next_word = (w >> 1) ^ (w[0] ? TAPS : ZERO);
            default: next_word = p;
        endcase
    endfunction

    // State and datapath registers; reset clears everything including latched settings.
    always_ff @(posedge clk_word or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            word_q    <= ZERO;
            cnt_q     <= 16'd0;
            mode_q    <= 2'b00;
            pattern_q <= ZERO;
            cont_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            cont_q    <= cont_d;
        end
    end

    assign last_s = (cnt_q == LAST_CNT);

    // Next-state logic: stop overrides start in IDLE and any transfer in SEND.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        cont_d    = cont_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d   = SEND;
                    mode_d    = mode;
                    pattern_d = pattern;
                    cont_d    = continuous;
                    word_d    = first_word(mode, pattern);
                    cnt_d     = 16'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (ready) begin
                    word_d = next_word(mode_q, word_q, pattern_q);
                    if (last_s) begin
                        cnt_d   = 16'd0;
                        state_d = cont_q ? SEND : IDLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    assign word       = word_q;
    assign word_cnt   = cnt_q;
    assign enable     = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    // Pulses in the cycle the final word is presented and accepted.
    assign frame_done = (state_q == SEND) && ready && !stop && last_s;

endmodule

// File: tb/tb_pattern_word_gen.sv
// Scoreboard bench for pattern_word_gen: stimulus pushes expected words from a
// sequence model; a negedge monitor compares whatever the DUT presents.
module tb_pattern_word_gen;
    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 8;
    localparam logic [WIDTH-1:0] TAPS = 8'hB8;

    logic             clk_word = 1'b0;
    logic             rst = 1'b0, start = 1'b0, stop = 1'b0, continuous = 1'b0;
    logic             ready = 1'b1, rand_ready = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] pattern = '0;
    logic [WIDTH-1:0] word;
    logic             enable, busy, frame_done;
    logic [15:0]      word_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [WIDTH-1:0] w;
        int               cnt;
        bit               last;
    } exp_t;
    exp_t sb[$];

    pattern_word_gen #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .TAPS(TAPS)) dut (
        .clk_word(clk_word), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .pattern(pattern), .continuous(continuous), .ready(ready), .word(word),
        .enable(enable), .busy(busy), .frame_done(frame_done), .word_cnt(word_cnt)
    );

    always #5 clk_word = ~clk_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // k-th word of a sequence started with mode m / pattern p, from the generator rules.
    function automatic logic [WIDTH-1:0] model_word(input logic [1:0] m, input logic [WIDTH-1:0] p, input int k);
        logic [WIDTH-1:0] v;
        case (m)
            2'd0: model_word = WIDTH'(1 << (k % WIDTH));
            2'd1: model_word = WIDTH'((k + 1) % (1 << WIDTH));
            2'd2: begin
                v = (p == '0) ? '1 : p;
                for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? TAPS : WIDTH'(0));
                model_word = v;
            end
            default: model_word = p;
        endcase
    endfunction

    task automatic push_frames(input logic [1:0] m, input logic [WIDTH-1:0] p, input int n);
        for (int k = 0; k < n * FRAME_LEN; k++)
            sb.push_back('{model_word(m, p, k), k % FRAME_LEN, (k % FRAME_LEN) == FRAME_LEN - 1});
    endtask

    task automatic issue_start(input logic [1:0] m, input logic [WIDTH-1:0] p, input logic cont);
        @(posedge clk_word); #1;
        mode = m; pattern = p; continuous = cont; start = 1'b1;
        @(posedge clk_word); #1;
        start = 1'b0;
        mode = 2'($urandom); pattern = WIDTH'($urandom); continuous = ~cont;
    endtask

    task automatic wait_drain(input bit expect_busy);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk_word); #1;
            if (expect_busy) check("busy_continuous", busy, 1);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_enable"}, enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        @(posedge clk_word); #1;
        stop = 1'b0;
    endtask

    // Random ready source, active only when requested.
    initial forever begin
        @(posedge clk_word); #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    end

    // Monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk_word) begin
        if (rst) begin
            if (enable) begin
                check("busy_in_send", busy, 1);
                if (stop) begin
                    check("frame_done_on_stop", frame_done, 0);
                end else if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0h expected no valid word", word);
                end else begin
                    check("word", word, sb[0].w);
                    check("word_cnt", word_cnt, sb[0].cnt);
                    check("frame_done", frame_done, ready && sb[0].last);
                    if (ready) void'(sb.pop_front());
                end
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
        end
    end

    initial begin
        #1;
        check("rst_word", word, 0);
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_word_cnt", word_cnt, 0);
        #12 rst = 1'b1;

        // walking one, always ready, single frame
        push_frames(2'd0, 8'h00, 1);
        issue_start(2'd0, 8'h00, 1'b0);
        wait_drain(1'b0);
        check_idle("walk_end");

        // counter, continuous across frames with wrap, random ready
        rand_ready = 1'b1;
        push_frames(2'd1, 8'h00, 40);
        issue_start(2'd1, 8'h00, 1'b1);
        wait_drain(1'b1);
        stop_pulse();
        check_idle("count_stop");

        // PRBS with zero seed, then a random nonzero seed in continuous mode
        push_frames(2'd2, 8'h00, 1);
        issue_start(2'd2, 8'h00, 1'b0);
        wait_drain(1'b0);
        check_idle("prbs0_end");
        begin
            logic [WIDTH-1:0] seed;
            seed = WIDTH'($urandom_range(1, 255));
            push_frames(2'd2, seed, 2);
            issue_start(2'd2, seed, 1'b1);
            wait_drain(1'b1);
            stop_pulse();
            check_idle("prbs_stop");
        end

        // fixed pattern with ready held low for 5 cycles
        rand_ready = 1'b0;
        ready = 1'b0;
        push_frames(2'd3, 8'hA5, 1);
        issue_start(2'd3, 8'hA5, 1'b0);
        repeat (4) @(posedge clk_word);
        #1 ready = 1'b1;
        wait_drain(1'b0);
        check_idle("fixed_end");

        // stop coinciding with the last transfer of a frame
        push_frames(2'd1, 8'h00, 1);
        issue_start(2'd1, 8'h00, 1'b0);
        for (int n = 0; n < 50 && sb.size() > 1; n++) begin
            @(posedge clk_word); #1;
        end
        check("stop_last_pending", sb.size(), 1);
        stop_pulse();
        sb.delete();
        check_idle("stop_last");

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        @(posedge clk_word); #1;
        start = 1'b0; stop = 1'b0;
        check_idle("start_stop");

        // asynchronous reset mid-frame, then a clean restart
        push_frames(2'd0, 8'h00, 1);
        issue_start(2'd0, 8'h00, 1'b0);
        repeat (3) @(posedge clk_word);
        #3 rst = 1'b0;
        #1;
        sb.delete();
        check("arst_word", word, 0);
        check("arst_enable", enable, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_done", frame_done, 0);
        check("arst_word_cnt", word_cnt, 0);
        @(negedge clk_word); #2 rst = 1'b1;
        push_frames(2'd0, 8'h00, 1);
        issue_start(2'd0, 8'h00, 1'b0);
        wait_drain(1'b0);
        check_idle("after_reset");

        // a few random single frames
        rand_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            logic [1:0]       m;
            logic [WIDTH-1:0] p;
            m = 2'($urandom);
            p = WIDTH'($urandom);
            push_frames(m, p, 1);
            issue_start(m, p, 1'b0);
            wait_drain(1'b0);
            check_idle("random_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
